// File: rtl/tx_slot_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tx_slot_arbiter: round-robin word arbiter feeding an MSB-first serial line.
// rev 1.0
// ----------------------------------------------------------------------------
module tx_slot_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16
) (
  input  logic                      CLK_24M,
  input  logic                      reset,
  input  logic                      enable_3M,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   data_in,
  output logic [N_REQ-1:0]          ack,
  output logic                      serial_out,
  output logic                      frame_sync,
  output logic                      active,
  output logic [$clog2(N_REQ)-1:0]  grant_id
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [PTR_W-1:0] c_LAST_IDX = PTR_W'(N_REQ - 1);
  localparam logic [PTR_W:0]   c_N_EXT    = (PTR_W + 1)'(N_REQ);
  localparam logic [CNT_W-1:0] c_CNT_TOP  = CNT_W'(DATA_W - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]        r_state;
  logic [PTR_W-1:0]  r_rr_ptr;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_serial;
  logic              r_frame;
  logic              r_active;
  logic [N_REQ-1:0]  r_ack;
  logic [PTR_W-1:0]  r_grant;

  logic [PTR_W-1:0]   w_start;
  logic [2*N_REQ-1:0] w_req2;
  logic [2*N_REQ-1:0] w_rot_full;
  logic [N_REQ-1:0]   w_rot;
  logic               w_found;
  logic [PTR_W-1:0]   w_off;
  logic [PTR_W:0]     w_sum;
  logic [PTR_W:0]     w_sum_wrap;
  logic [PTR_W-1:0]   w_win;
  logic [DATA_W-1:0]  w_word;
  logic [N_REQ-1:0]   w_onehot;
  logic               w_arb;

  // Rotate requests so the search always begins at bit 0 = rr_ptr+1.
  assign w_start    = (r_rr_ptr == c_LAST_IDX) ? '0 : r_rr_ptr + 1'b1;
  assign w_req2     = {req, req};
  assign w_rot_full = w_req2 >> w_start;
  assign w_rot      = w_rot_full[N_REQ-1:0];

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_found = 1'b1;
        w_off   = PTR_W'(j);
      end
    end
  end

  assign w_sum      = {1'b0, w_start} + {1'b0, w_off};
  assign w_sum_wrap = w_sum - c_N_EXT;
  assign w_win      = (w_sum >= c_N_EXT) ? w_sum_wrap[PTR_W-1:0] : w_sum[PTR_W-1:0];

  always_comb begin
    w_word   = '0;
    w_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == PTR_W'(i)) begin
        w_word      = data_in[i*DATA_W +: DATA_W];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // A word boundary: idle line, or the LSB of the current word has had its period.
  assign w_arb = enable_3M && ((r_state == S_IDLE) || (r_bit_cnt == '0));

  always_ff @(posedge CLK_24M) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= c_LAST_IDX;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_serial  <= 1'b0;
      r_frame   <= 1'b0;
      r_active  <= 1'b0;
      r_ack     <= '0;
      r_grant   <= '0;
    end else begin
      r_ack <= '0;
      if (w_arb) begin
        if (w_found) begin
          r_state   <= S_SHIFT;
          r_shift   <= w_word;
          r_serial  <= w_word[DATA_W-1];
          r_bit_cnt <= c_CNT_TOP;
          r_frame   <= 1'b1;
          r_active  <= 1'b1;
          r_grant   <= w_win;
          r_rr_ptr  <= w_win;
          r_ack     <= w_onehot;
        end else begin
          r_state  <= S_IDLE;
          r_serial <= 1'b0;
          r_frame  <= 1'b0;
          r_active <= 1'b0;
        end
      end else if (enable_3M) begin
        r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
        r_serial  <= r_shift[DATA_W-2];
        r_bit_cnt <= r_bit_cnt - 1'b1;
        r_frame   <= 1'b0;
      end
    end
  end

  assign ack        = r_ack;
  assign serial_out = r_serial;
  assign frame_sync = r_frame;
  assign active     = r_active;
  assign grant_id   = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_tx_slot_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tx_slot_arbiter: directed + random stimulus against a bit-queue model.
// ----------------------------------------------------------------------------
module tb_tx_slot_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int PW = 2;

  logic              CLK_24M = 1'b0;
  logic              reset;
  logic              enable_3M;
  logic [N-1:0]      req;
  logic [N*W-1:0]    data_in;
  logic [N-1:0]      ack;
  logic              serial_out;
  logic              frame_sync;
  logic              active;
  logic [PW-1:0]     grant_id;

  tx_slot_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .CLK_24M(CLK_24M), .reset(reset), .enable_3M(enable_3M), .req(req),
    .data_in(data_in), .ack(ack), .serial_out(serial_out),
    .frame_sync(frame_sync), .active(active), .grant_id(grant_id)
  );

  always #5 CLK_24M = ~CLK_24M;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a word becomes a queue of bits; the line pops one per strobe.
  int          m_rr;
  bit          m_q[$];
  logic        m_serial, m_fs, m_active;
  logic [N-1:0] m_ack;
  int          m_gid;

  task automatic model_edge();
    int w;
    logic [W-1:0] word;
    if (reset) begin
      m_q.delete();
      m_serial = 1'b0; m_fs = 1'b0; m_active = 1'b0; m_ack = '0; m_gid = 0; m_rr = N - 1;
    end else begin
      m_ack = '0;
      if (enable_3M) begin
        if (m_q.size() == 0) begin
          w = -1;
          for (int k = 1; k <= N; k++)
            if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
          if (w >= 0) begin
            word = data_in[w*W +: W];
            for (int b = W - 1; b >= 0; b--) m_q.push_back(word[b]);
            m_serial = m_q.pop_front();
            m_fs = 1'b1; m_active = 1'b1; m_gid = w; m_rr = w;
            m_ack = N'(1) << w;
          end else begin
            m_serial = 1'b0; m_fs = 1'b0; m_active = 1'b0;
          end
        end else begin
          m_serial = m_q.pop_front();
          m_fs = 1'b0;
        end
      end
    end
  endtask

  bit           nominal = 1'b1;
  int           phase = 0;
  int           n_strobe = 0;
  logic [W-1:0] cap;
  int           cap_bits = 0;
  logic [W-1:0] wq[$];
  int           gq[$];

  task automatic tick();
    logic en_e;
    @(posedge CLK_24M);
    en_e = enable_3M;
    model_edge();
    #1;
    chk_eq("serial_out", serial_out, m_serial);
    chk_eq("frame_sync", frame_sync, m_fs);
    chk_eq("active", active, m_active);
    chk_eq("ack", ack, m_ack);
    chk_eq("grant_id", grant_id, m_gid);
    if (reset) cap_bits = 0;
    else if (en_e) begin
      n_strobe++;
      if (frame_sync) begin
        cap = W'(serial_out); cap_bits = 1;
      end else if (active && cap_bits > 0) begin
        cap = {cap[W-2:0], serial_out}; cap_bits++;
      end
      if (cap_bits == W) begin
        wq.push_back(cap); gq.push_back(int'(grant_id)); cap_bits = 0;
      end
    end
    if (nominal) begin
      phase = (phase + 1) % 8;
      enable_3M = (phase == 0);
    end else begin
      enable_3M = ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ack(input int maxc, output int cycles, output logic [N-1:0] got);
    cycles = 0; got = '0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      cycles++;
      if (ack != '0) begin
        got = ack;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0;
    tick(); tick();
    reset = 1'b0;
    cap_bits = 0; wq.delete(); gq.delete();
  endtask

  int           cyc;
  logic [N-1:0] got;
  int           fs_cnt, act_cnt;
  bit           seen, dropped;
  int           s0;
  int           exp_g[5];

  initial begin
    reset = 1'b1; enable_3M = 1'b0; req = '0; data_in = '0;

    // Reset state
    do_reset();
    chk_eq("rst_grant_id", grant_id, 0);
    chk_eq("rst_active", active, 0);
    chk_eq("rst_serial", serial_out, 0);

    // Single requester, 0xA5C3 on requester 2
    data_in[2*W +: W] = 16'hA5C3;
    req = 4'b0100;
    wait_ack(20, cyc, got);
    chk_eq("single_ack", got, 4'b0100);
    req = '0;
    fs_cnt = int'(frame_sync); act_cnt = int'(active);
    for (int i = 0; i < 140; i++) begin
      tick();
      fs_cnt += int'(frame_sync);
      act_cnt += int'(active);
    end
    chk_eq("single_fs_cycles", fs_cnt, 8);
    chk_eq("single_active_cycles", act_cnt, 128);
    chk_eq("single_word", wq.size() > 0 ? wq[0] : 16'h0, 16'hA5C3);

    // All four held: 0,1,2,3,0 with no gap
    do_reset();
    for (int i = 0; i < N; i++) data_in[i*W +: W] = W'(16'h1111 * (i + 1));
    req = 4'b1111;
    seen = 1'b0; dropped = 1'b0;
    for (int i = 0; i < 660; i++) begin
      tick();
      if (active) seen = 1'b1;
      else if (seen) dropped = 1'b1;
    end
    chk_eq("all4_no_drop", dropped, 1'b0);
    exp_g = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      chk_eq("all4_grant", gq.size() > k ? gq[k] : -1, exp_g[k]);
      chk_eq("all4_word", wq.size() > k ? wq[k] : 16'h0, W'(16'h1111 * (exp_g[k] + 1)));
    end

    // Round-robin from rr_ptr=1 with req=1010: 3,1,3
    do_reset();
    data_in = {16'hD00D, 16'hC00C, 16'hB00B, 16'hA00A};
    req = 4'b0010;
    wait_ack(20, cyc, got);
    chk_eq("rr_first_ack", got, 4'b0010);
    req = 4'b1010;
    run(4 * 128 + 16);
    exp_g = '{1, 3, 1, 3, 0};
    for (int k = 1; k < 4; k++)
      chk_eq("rr_grant", gq.size() > k ? gq[k] : -1, exp_g[k]);
    req = '0;
    run(140);

    // Reset mid-word
    do_reset();
    data_in[0 +: W] = 16'h1234;
    req = 4'b0001;
    wait_ack(20, cyc, got);
    req = '0;
    s0 = n_strobe;
    for (int i = 0; i < 64 && n_strobe < s0 + 5; i++) tick();
    chk_eq("midrst_in_word", active, 1'b1);
    reset = 1'b1;
    tick();
    chk_eq("midrst_serial", serial_out, 1'b0);
    chk_eq("midrst_active", active, 1'b0);
    chk_eq("midrst_ack", ack, 4'b0000);
    reset = 1'b0;
    tick();
    req = 4'b1001;
    wait_ack(20, cyc, got);
    chk_eq("midrst_after_ack", got, 4'b0001);
    req = '0;
    run(140);

    // Strobe alignment
    do_reset();
    data_in[1*W +: W] = 16'h0F0F;
    for (int i = 0; i < 16 && !enable_3M; i++) tick();
    req = 4'b0010;
    tick();
    chk_eq("align_same_ack", ack, 4'b0010);
    req = '0;
    run(140);
    for (int i = 0; i < 16 && !enable_3M; i++) tick();
    tick();
    req = 4'b0010;
    wait_ack(20, cyc, got);
    chk_eq("align_late_ack", got, 4'b0010);
    chk_eq("align_late_cycles", cyc, 8);
    req = '0;
    run(140);

    // Data stability after ack
    do_reset();
    data_in[0 +: W] = 16'hBEEF;
    req = 4'b0001;
    wait_ack(20, cyc, got);
    req = '0;
    data_in[0 +: W] = 16'h0000;
    run(3);
    data_in[0 +: W] = 16'h5555;
    run(140);
    chk_eq("stable_word", wq.size() > 0 ? wq[0] : 16'h0, 16'hBEEF);

    // Randomized traffic, nominal and irregular strobes, occasional reset
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      nominal = (i < 1500) || (i >= 3000);
      reset = ($urandom_range(0, 599) == 0);
      for (int r = 0; r < N; r++) begin
        if (!req[r]) begin
          data_in[r*W +: W] = W'($urandom);
          if ($urandom_range(0, 15) == 0) req[r] = 1'b1;
        end
      end
      tick();
      for (int r = 0; r < N; r++) begin
        if (ack[r]) begin
          if ($urandom_range(0, 1) == 0) req[r] = 1'b0;
          data_in[r*W +: W] = W'($urandom);
        end
      end
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tx_slot_arbiter.md
# tx_slot_arbiter

Round-robin arbiter and serializer that shares one serial output line between `N_REQ` requesters. It runs in the `CLK_24M` domain. It consumes the one-in-eight `enable_3M` bit strobe from the clock generator, so the line advances one bit per 3 MHz period. It grants whole words, MSB first, back-to-back with no idle bit between words while requests are pending.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, minimum 2.
- `DATA_W`, default 16: word width in bits, minimum 2.

Ports:
- `CLK_24M`, in, 1: system clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `enable_3M`, in, 1: bit strobe, nominally high for 1 cycle in every 8.
- `req`, in, `N_REQ`: per-requester word-ready request. Level-held until acked.
- `data_in`, in, `N_REQ*DATA_W`: requester i's word at `[i*DATA_W +: DATA_W]`.
- `ack`, out, `N_REQ`: one-hot, 1-cycle pulse. Marks that requester's word as captured.
- `serial_out`, out, 1: serial data, MSB first.
- `frame_sync`, out, 1: high during the first bit period of every word.
- `active`, out, 1: high while a word is on the line.
- `grant_id`, out, `$clog2(N_REQ)`: index of the requester currently (or last) granted.

## Operation
- States: IDLE and SHIFT. Registered `rr_ptr` holds the last granted index.
- Arbitration event: a rising edge where `enable_3M`=1 and either:
  - the state is IDLE, or
  - the state is SHIFT and `bit_cnt`=0.
- Winner selection:
  - Search `req` starting at `rr_ptr+1` mod `N_REQ`; the first set bit wins.
  - With `rr_ptr`=`N_REQ-1` after reset, requester 0 has top priority.
- On an arbitration event with a winner w:
  - `shift_reg` ← `data_in[w]`; `serial_out` ← `data_in[w]` MSB.
  - `bit_cnt` ← `DATA_W-1`; `frame_sync` ← 1; `active` ← 1.
  - `grant_id` ← w; `rr_ptr` ← w; `ack` ← one-hot(w).
  - State becomes SHIFT.
- On an arbitration event with no request:
  - State becomes IDLE; `serial_out` ← 0; `frame_sync` ← 0; `active` ← 0.
  - `grant_id` and `rr_ptr` hold.
- SHIFT, `enable_3M`=1, `bit_cnt`>0:
  - Shift left; `serial_out` ← next bit.
  - `bit_cnt` decrements; `frame_sync` ← 0.
- `enable_3M`=0: every register holds, except `ack`, which returns to 0.
- `data_in` is sampled only at the arbitration edge. Later changes to it do not affect the word in flight.
- `req` dropped before an arbitration edge: that requester is not considered. No memory of past requests.
- Consecutive `enable_3M` cycles (off-nominal): each one counts as a bit tick. There is no special handling.

## Timing
- Reset values (one edge after `reset`=1):
  - `serial_out`=0, `frame_sync`=0, `active`=0, `ack`=0, `grant_id`=0.
  - `rr_ptr`=`N_REQ-1`, `bit_cnt`=0, state IDLE.
- Reset has priority over everything:
  - It aborts a word mid-flight; the remaining bits are lost.
  - No `ack` is emitted on that edge.
  - `enable_3M` is ignored while `reset`=1.
- `ack` latency:
  - High for exactly the one cycle after the arbitration edge.
  - A requester may deassert or change `req`/`data_in` from that cycle on.
  - A request that is still held after its ack is re-arbitrated as a new word.
- `req` set in the same cycle as an `enable_3M` (IDLE): granted on that edge.
- `req` set one cycle later: waits for the next strobe, 8 cycles nominally.
- Bit period: `serial_out` changes only on edges where `enable_3M`=1. At the nominal rate each bit lasts 8 cycles.
- Word duration: `DATA_W` bit periods (128 cycles at the defaults).
- Back-to-back words: the next word's MSB follows the previous LSB at the very next strobe, with no gap.
- `active` stays high continuously across back-to-back words.
- `frame_sync` and `active` are aligned to `serial_out`, all registered on the same edge.

## Test plan
- Single requester (defaults): `req[2]`=1, `data_in[2]`=0xA5C3, held until ack.
  - `ack`=0b0100 for 1 cycle after the first strobe edge.
  - `serial_out` = 1010010111000011, 8 cycles per bit.
  - `frame_sync` high for the first 8 cycles; `active` high for 128 cycles, then 0.
- All four `req` held continuously:
  - Grants follow 0,1,2,3,0 with `grant_id` matching.
  - No idle bit between words; `active` never drops.
- Round-robin order: `rr_ptr`=1, `req`=0b1010 held. Grant order is 3, then 1, then 3.
- Reset mid-word: assert `reset` at bit 5 of a word.
  - Next edge: `serial_out`=0, `active`=0, no `ack`.
  - After release, `req`=0b1001 gives requester 0 first.
- Strobe alignment:
  - `req[1]` asserted in the strobe cycle (IDLE) is granted that edge.
  - Asserted 1 cycle after the strobe, it is granted 8 cycles later.
- Data stability: change `data_in[0]` mid-word after its ack. The transmitted word is unchanged.
